// File: rtl/ahblite_uart_slave_pkg.sv
// Shared definitions for the AHB-Lite UART slave: register offsets,
// status bit positions, serial FSM state encodings, data-phase record.
package ahblite_uart_slave_pkg;

  // Word offsets decoded from HADDR[3:2]
  localparam logic [1:0] RX_DATA  = 2'd0;
  localparam logic [1:0] TX_STATE = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;

  // Bit positions inside the TX STATE word
  localparam int ST_TX_BUSY   = 0;
  localparam int ST_RX_VALID  = 1;
  localparam int ST_OVERRUN   = 2;
  localparam int ST_FRAME_ERR = 3;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_BITS, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_e;

  // Address-phase capture carried into the data phase
  typedef struct packed {
    logic       rd;
    logic       wr;
    logic [1:0] addr;
  } ahb_dphase_t;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: two-flop synchronizer, half-bit start qualification,
// mid-bit sampling, plus the rx_valid / overrun / frame_err flags.
// Flag sets take priority over bus-driven clears in the same cycle.
module uart_rx_core
  import ahblite_uart_slave_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  input  logic       clr_valid,
  input  logic       clr_err,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       overrun,
  output logic       frame_err
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);

  logic [1:0]    sync;
  logic          rxs;
  rx_state_e     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  assign rxs = sync[1];

  // Metastability guard on the asynchronous serial input, idles high
  always_ff @(posedge clk) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], rxd};
  end

  // Receive FSM and status flags (set beats clear)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (clr_valid) rx_valid <= 1'b0;
      if (clr_err) begin
        overrun   <= 1'b0;
        frame_err <= 1'b0;
      end
      case (state)
        RX_IDLE: begin
          if (!rxs) begin
            cnt   <= '0;
            state <= RX_START;
          end
        end
        RX_START: begin
          if (cnt == HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rxs ? RX_IDLE : RX_BITS;
          end else cnt <= cnt + 1'b1;
        end
        RX_BITS: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            shreg   <= {rxs, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else cnt <= cnt + 1'b1;
        end
        RX_STOP: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rxs) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
              if (rx_valid) overrun <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else cnt <= cnt + 1'b1;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_core.sv
// 8N1 transmitter: START, 8 data bits LSB first, STOP, each BAUD_DIV cycles.
// busy stays high for one idle cycle after STOP so a write landing in that
// cycle is still refused.
module uart_tx_core
  import ahblite_uart_slave_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] data,
  output logic       txd,
  output logic       busy
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  tx_state_e     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  // Transmit FSM with registered line and busy outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= TX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      txd     <= 1'b1;
      busy    <= 1'b0;
    end else begin
      case (state)
        TX_IDLE: begin
          busy <= 1'b0;
          txd  <= 1'b1;
          if (load && !busy) begin
            shreg <= data;
            cnt   <= '0;
            txd   <= 1'b0;
            busy  <= 1'b1;
            state <= TX_START;
          end
        end
        TX_START: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            txd     <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            state   <= TX_BITS;
          end else cnt <= cnt + 1'b1;
        end
        TX_BITS: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              txd   <= 1'b1;
              state <= TX_STOP;
            end else begin
              txd     <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end else cnt <= cnt + 1'b1;
        end
        TX_STOP: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= TX_IDLE;
          end else cnt <= cnt + 1'b1;
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ahblite_uart_slave.sv
// AHB-Lite UART slave: zero-wait register front end over TX/RX cores.
module ahblite_uart_slave
  import ahblite_uart_slave_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [3:0]  HPROT,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  input  logic        RXD,
  output logic        TXD,
  output logic        IRQ
);
  ahb_dphase_t dp;
  logic        accept;
  logic        tx_busy, tx_load;
  logic [7:0]  rx_data;
  logic        rx_valid, overrun, frame_err;
  logic        unused_bits;

  assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HSIZE, HPROT, HWDATA[31:8]};

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign IRQ       = rx_valid;
  assign accept    = HSEL & HTRANS[1] & HREADY;
  assign tx_load   = dp.wr && (dp.addr == TX_DATA) && !tx_busy;

  // Capture the address phase; any non-accepted cycle clears the data phase
  always_ff @(posedge HCLK) begin
    if (!HRESETn) dp <= '0;
    else begin
      dp.rd   <= accept & ~HWRITE;
      dp.wr   <= accept &  HWRITE;
      dp.addr <= accept ? HADDR[3:2] : 2'd0;
    end
  end

  // Read mux, driven only during a read data phase
  always_comb begin
    HRDATA = '0;
    if (dp.rd) begin
      case (dp.addr)
        RX_DATA:  HRDATA[7:0] = rx_data;
        TX_STATE: begin
          HRDATA[ST_TX_BUSY]   = tx_busy;
          HRDATA[ST_RX_VALID]  = rx_valid;
          HRDATA[ST_OVERRUN]   = overrun;
          HRDATA[ST_FRAME_ERR] = frame_err;
        end
        default: ;
      endcase
    end
  end

  uart_tx_core #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .load  (tx_load),
    .data  (HWDATA[7:0]),
    .txd   (TXD),
    .busy  (tx_busy)
  );

  uart_rx_core #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .rxd       (RXD),
    .clr_valid (dp.rd && (dp.addr == RX_DATA)),
    .clr_err   (dp.rd && (dp.addr == TX_STATE)),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

endmodule

// File: doc/ahblite_uart_slave.md
# ahblite_uart_slave

AHB-Lite slave implementing the UART peripheral at 0x40000010–0x4000001B, behind the system address decoder's UART select (P3). Holds one TX shifter and one RX deserializer (8N1, LSB first) with a programmable-at-build baud divider. Exposes three word registers: RX DATA, TX STATE and TX DATA. Zero-wait-state, never errors.

## Interface
- BAUD_DIV, 434: HCLK cycles per bit (50 MHz / 115200); legal ≥ 4.
- HCLK  in  1  system clock.
- HRESETn  in  1  synchronous, active-low reset.
- HSEL  in  1  slave select from address decoder.
- HADDR  in  32  address; only HADDR[3:2] decoded.
- HTRANS  in  2  transfer type; HTRANS[1]=1 means NONSEQ/SEQ.
- HSIZE  in  3  ignored; all accesses treated as word.
- HPROT  in  4  ignored.
- HWRITE  in  1  1 = write.
- HWDATA  in  32  write data, data phase.
- HREADY  in  1  bus ready, qualifies address phase.
- HREADYOUT  out  1  constant 1.
- HRESP  out  1  constant 0 (OKAY).
- HRDATA  out  32  read data, data phase.
- RXD  in  1  serial input, asynchronous.
- TXD  out  1  serial output, idle high.
- IRQ  out  1  equals rx_valid.

## Operation
- Address phase accepted when HSEL & HTRANS[1] & HREADY; register HADDR[3:2], HWRITE into data-phase flags; otherwise flags cleared.
- Register map (offset): 0x0 RX DATA (R: {24'b0, rx_data}); 0x4 TX STATE (R: {28'b0, frame_err, overrun, rx_valid, tx_busy}); 0x8 TX DATA (W: HWDATA[7:0]). Offset 0xC reads 0, writes ignored. Writes to 0x0/0x4 ignored.
- Read 0x0: clears rx_valid at end of data phase. Read 0x4: clears overrun and frame_err at end of data phase (value returned is pre-clear).
- Write 0x8 with tx_busy=0: load shifter, tx_busy←1 next cycle. Write with tx_busy=1: discarded, no flag.
- TX FSM: IDLE → START (TXD=0) → DATA ×8 (LSB first) → STOP (TXD=1) → IDLE; each state/bit held exactly BAUD_DIV cycles. tx_busy=1 in START..STOP.
- RX: RXD through 2-flop synchronizer (reset 1). IDLE: on synced 0 → START, wait BAUD_DIV/2; if still 0 → DATA, else back to IDLE (glitch). DATA: sample every BAUD_DIV, 8 bits. STOP: sample after BAUD_DIV; 1 → rx_data←byte, rx_valid←1, overrun←1 if rx_valid was already 1; 0 → discard byte, frame_err←1. Then IDLE.
- Counter widths: $clog2(BAUD_DIV) bits baud counter, 3-bit bit index.

## Timing
- Reset values: TXD=1, HRDATA=0, IRQ=0, tx_busy=0, rx_valid=0, overrun=0, frame_err=0, rx_data=0, both FSMs IDLE, flags cleared.
- HRDATA combinational from data-phase address and registers; valid in the data-phase cycle; 0 when no read in data phase.
- TX: first START cycle on TXD is 1 cycle after the write data phase; frame = 10×BAUD_DIV cycles; tx_busy falls in the cycle after STOP's last cycle; a write in that same cycle's data phase is discarded.
- RX: rx_valid rises 2 (sync) + BAUD_DIV/2 + 9×BAUD_DIV cycles after RXD falling edge.
- Simultaneous RX completion and RX DATA read: read returns old byte, new byte stored, rx_valid stays 1, overrun set (old byte was valid). Simultaneous flag set and TX STATE read: set wins.
- Reset mid-frame: TXD returns to 1 next edge, in-flight byte lost.

## Structure
- Shared package: register offsets (RX_DATA=2'd0, TX_STATE=2'd1, TX_DATA=2'd2), status bit indices, TX/RX state enums.
- Sub-modules: uart_tx_core (shifter + TX FSM) and uart_rx_core (synchronizer + RX FSM); AHB register logic stays in top.

## Test plan
- Reset with BAUD_DIV=4: TXD=1, IRQ=0, read 0x40000014 → 0x0.
- Write 0x40000018 = 0x000000A5: TXD = 0, then 1,0,1,0,0,1,0,1, then 1, 4 cycles each; TX STATE bit0=1 during, 0 after 40 cycles.
- Second write 0x3C during busy: discarded, only 0xA5 frame on TXD.
- Drive RXD frame 0x5A: IRQ=1, read 0x40000010 → 0x5A, IRQ=0 next cycle.
- Two frames 0x11, 0x22 unread: RX DATA=0x22, TX STATE=0x6; after read of 0x4, overrun cleared.
- RXD stop bit 0 → TX STATE bit3=1, rx_valid=0; 1-cycle low glitch on idle RXD → no reception, no flags.
